// File: rtl/esteira_multiestacao_pkg.sv
// +--------------------------------------------------------------------+
// | pkg_esteira: shared types and defaults for the conveyor controller |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package pkg_esteira;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MOVENDO   = 3'd1,
    ST_PAUSADO   = 3'd2,
    ST_CONCLUIDO = 3'd3,
    ST_FALHA     = 3'd4
  } estado_esteira_t;

  localparam int FILTRO_CICLOS_PADRAO  = 4;
  localparam int TIMEOUT_CICLOS_PADRAO = 500_000_000;

  // A single station still needs a 1-bit index port.
  function automatic int calc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/esteira_multiestacao_contador.sv
// +--------------------------------------------------------------------+
// | contador_saturado: saturating counter with clr/hold/inc and a flag |
// | that fires on the increment that reaches LIMITE. Rev 1.0           |
// +--------------------------------------------------------------------+
`default_nettype none

module contador_saturado #(
  parameter int LIMITE = 4,
  parameter int W      = $clog2(LIMITE + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic hold_i,
  input  logic inc_i,
  output logic terminal_o
);

  localparam logic [W-1:0] c_limite = W'(LIMITE);
  localparam logic [W-1:0] c_ultimo = W'(LIMITE - 1);

  logic [W-1:0] valor_q, valor_d;
  logic         w_avanca;

  assign w_avanca   = inc_i && !hold_i && !clr_i;
  // Flag is combinational so the caller can act on the same edge the limit is reached.
  assign terminal_o = w_avanca && (valor_q == c_ultimo);

  always_comb begin
    valor_d = valor_q;
    if (clr_i) begin
      valor_d = '0;
    end else if (w_avanca && (valor_q != c_limite)) begin
      valor_d = valor_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valor_q <= '0;
    end else begin
      valor_q <= valor_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/esteira_multiestacao.sv
// +--------------------------------------------------------------------+
// | esteira_multiestacao: multi-station conveyor motion controller     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module esteira_multiestacao
  import pkg_esteira::*;
#(
  parameter int  N_ESTACOES     = 3,
  parameter int  FILTRO_CICLOS  = FILTRO_CICLOS_PADRAO,
  parameter int  TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO,
  localparam int IDX_W          = calc_idx_w(N_ESTACOES)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  input  logic [IDX_W-1:0]      cmd_destino,
  output logic                  cmd_ready,
  input  logic [N_ESTACOES-1:0] sensores,
  input  logic                  alarme_rolha,
  input  logic                  limpar_falha,
  output logic                  motor_ativo,
  output logic                  tarefa_concluida,
  output logic                  cmd_erro,
  output logic                  falha_timeout,
  output logic [IDX_W-1:0]      estacao_atual
);

  localparam logic [IDX_W:0] c_n_estacoes = (IDX_W + 1)'(N_ESTACOES);

  estado_esteira_t estado_q, estado_d;
  logic [IDX_W-1:0] dest_q, dest_d;
  logic [IDX_W-1:0] estacao_q, estacao_d;
  logic cmd_ready_q, motor_q, tarefa_q, erro_q, falha_q;
  logic erro_d;

  logic w_dest_valido, w_sensor_dest, w_pausado;
  logic w_filt_clr, w_filt_inc, w_filt_term;
  logic w_to_clr, w_to_inc, w_to_term;

  assign w_dest_valido = ({1'b0, cmd_destino} < c_n_estacoes);
  assign w_sensor_dest = sensores[dest_q];
  assign w_pausado     = (estado_q == ST_PAUSADO);

  contador_saturado #(.LIMITE(FILTRO_CICLOS)) u_filtro (
    .clk        (clk),
    .rst_n      (reset_n),
    .clr_i      (w_filt_clr),
    .hold_i     (w_pausado),
    .inc_i      (w_filt_inc),
    .terminal_o (w_filt_term)
  );

  contador_saturado #(.LIMITE(TIMEOUT_CICLOS)) u_timeout (
    .clk        (clk),
    .rst_n      (reset_n),
    .clr_i      (w_to_clr),
    .hold_i     (w_pausado),
    .inc_i      (w_to_inc),
    .terminal_o (w_to_term)
  );

  always_comb begin
    estado_d   = estado_q;
    dest_d     = dest_q;
    erro_d     = 1'b0;
    w_filt_clr = 1'b0;
    w_filt_inc = 1'b0;
    w_to_clr   = 1'b0;
    w_to_inc   = 1'b0;
    unique case (estado_q)
      ST_IDLE: begin
        if (cmd_valid && w_dest_valido) begin
          dest_d     = cmd_destino;
          w_filt_clr = 1'b1;
          w_to_clr   = 1'b1;
          estado_d   = ST_MOVENDO;
        end else if (cmd_valid) begin
          erro_d = 1'b1;
        end
      end
      ST_MOVENDO: begin
        // Counters only advance on edges that keep the belt running.
        if (alarme_rolha) begin
          estado_d = ST_PAUSADO;
        end else begin
          w_to_inc   = 1'b1;
          w_filt_inc = w_sensor_dest;
          w_filt_clr = !w_sensor_dest;
          if (w_filt_term) begin
            estado_d = ST_CONCLUIDO;
          end else if (w_to_term) begin
            estado_d = ST_FALHA;
          end
        end
      end
      ST_PAUSADO: begin
        if (!alarme_rolha) begin
          w_filt_clr = 1'b1;
          estado_d   = ST_MOVENDO;
        end
      end
      ST_CONCLUIDO: estado_d = ST_IDLE;
      ST_FALHA: begin
        if (limpar_falha) begin
          estado_d = ST_IDLE;
        end
      end
      default: estado_d = ST_IDLE;
    endcase
  end

  assign estacao_d = (estado_d == ST_CONCLUIDO) ? dest_q : estacao_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_q    <= ST_IDLE;
      dest_q      <= '0;
      estacao_q   <= '0;
      cmd_ready_q <= 1'b1;
      motor_q     <= 1'b0;
      tarefa_q    <= 1'b0;
      erro_q      <= 1'b0;
      falha_q     <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      dest_q      <= dest_d;
      estacao_q   <= estacao_d;
      cmd_ready_q <= (estado_d == ST_IDLE);
      motor_q     <= (estado_d == ST_MOVENDO);
      tarefa_q    <= (estado_d == ST_CONCLUIDO);
      erro_q      <= erro_d;
      falha_q     <= (estado_d == ST_FALHA);
    end
  end

  assign cmd_ready        = cmd_ready_q;
  assign motor_ativo      = motor_q;
  assign tarefa_concluida = tarefa_q;
  assign cmd_erro         = erro_q;
  assign falha_timeout    = falha_q;
  assign estacao_atual    = estacao_q;

endmodule

`default_nettype wire

// File: tb/tb_esteira_multiestacao.sv
// +--------------------------------------------------------------------+
// | tb_esteira_multiestacao: table, directed and random checks against |
// | a behavioural model of the conveyor controller. Rev 1.0            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_esteira_multiestacao;

  localparam int N = 3;
  localparam int F = 3;
  localparam int T = 20;

  logic       clk = 1'b0;
  logic       reset_n, cmd_valid, alarme_rolha, limpar_falha;
  logic [1:0] cmd_destino;
  logic [2:0] sensores;
  logic       cmd_ready, motor_ativo, tarefa_concluida, cmd_erro, falha_timeout;
  logic [1:0] estacao_atual;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  esteira_multiestacao #(
    .N_ESTACOES    (N),
    .FILTRO_CICLOS (F),
    .TIMEOUT_CICLOS(T)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cmd_valid       (cmd_valid),
    .cmd_destino     (cmd_destino),
    .cmd_ready       (cmd_ready),
    .sensores        (sensores),
    .alarme_rolha    (alarme_rolha),
    .limpar_falha    (limpar_falha),
    .motor_ativo     (motor_ativo),
    .tarefa_concluida(tarefa_concluida),
    .cmd_erro        (cmd_erro),
    .falha_timeout   (falha_timeout),
    .estacao_atual   (estacao_atual)
  );

  // Outputs packed as {ready, motor, tarefa, erro, falha, estacao[1:0]}
  typedef struct packed {
    logic       valid;
    logic [1:0] dest;
    logic [2:0] sens;
    logic       alarm;
    logic       limpar;
    logic [6:0] esp;
  } vetor_t;

  vetor_t tab [0:10];

  // Behavioural model: 0 idle, 1 moving, 2 paused, 3 arrived, 4 fault
  int         m_modo, m_alvo, m_seq, m_tempo;
  logic       m_erro;
  logic [1:0] m_est;

  task automatic modelo_reset();
    m_modo = 0; m_alvo = 0; m_seq = 0; m_tempo = 0; m_erro = 1'b0; m_est = 2'd0;
  endtask

  task automatic modelo_passo();
    m_erro = 1'b0;
    case (m_modo)
      0: if (cmd_valid) begin
           if (int'(cmd_destino) < N) begin
             m_modo = 1; m_alvo = int'(cmd_destino); m_seq = 0; m_tempo = 0;
           end else begin
             m_erro = 1'b1;
           end
         end
      1: if (alarme_rolha) begin
           m_modo = 2;
         end else begin
           m_tempo = m_tempo + 1;
           m_seq   = sensores[m_alvo] ? m_seq + 1 : 0;
           if (m_seq >= F) begin
             m_modo = 3; m_est = 2'(m_alvo);
           end else if (m_tempo >= T) begin
             m_modo = 4;
           end
         end
      2: if (!alarme_rolha) begin m_seq = 0; m_modo = 1; end
      3: m_modo = 0;
      4: if (limpar_falha) m_modo = 0;
      default: m_modo = 0;
    endcase
  endtask

  function automatic logic [6:0] modelo_saidas();
    return {m_modo == 0, m_modo == 1, m_modo == 3, m_erro, m_modo == 4, m_est};
  endfunction

  task automatic verificar(input string nome, input logic [6:0] esperado);
    logic [6:0] obtido;
    obtido = {cmd_ready, motor_ativo, tarefa_concluida, cmd_erro, falha_timeout, estacao_atual};
    n_vec++;
    if (obtido !== esperado) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (rdy,mot,tar,err,flt,est)", nome, obtido, esperado);
    end
  endtask

  task automatic checar(input string nome, input int obtido, input int esperado);
    n_vec++;
    if (obtido != esperado) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nome, obtido, esperado);
    end
  endtask

  task automatic entradas(input logic v, input logic [1:0] d, input logic [2:0] s,
                          input logic a, input logic l);
    cmd_valid = v; cmd_destino = d; sensores = s; alarme_rolha = a; limpar_falha = l;
  endtask

  task automatic passo(input string nome);
    @(posedge clk);
    modelo_passo();
    @(negedge clk);
    verificar(nome, modelo_saidas());
  endtask

  task automatic reset_sincronizado();
    reset_n = 1'b0;
    modelo_reset();
    @(negedge clk);
    verificar("reset", 7'b1000000);
    reset_n = 1'b1;
  endtask

  initial begin
    int  k;
    logic viu_tarefa, viu_falha;

    reset_n = 1'b0;
    entradas(1'b0, 2'd0, 3'b000, 1'b0, 1'b0);
    modelo_reset();
    @(negedge clk);
    @(negedge clk);
    verificar("reset_inicial", 7'b1000000);
    reset_n = 1'b1;

    // Normal move to station 1 followed by an out-of-range command.
    tab[0]  = '{1'b1, 2'd1, 3'b000, 1'b0, 1'b0, 7'b0100000};
    tab[1]  = '{1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 7'b0100000};
    tab[2]  = '{1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 7'b0100000};
    tab[3]  = '{1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 7'b0100000};
    tab[4]  = '{1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 7'b0100000};
    tab[5]  = '{1'b0, 2'd0, 3'b010, 1'b0, 1'b0, 7'b0100000};
    tab[6]  = '{1'b0, 2'd0, 3'b010, 1'b0, 1'b0, 7'b0100000};
    tab[7]  = '{1'b0, 2'd0, 3'b010, 1'b0, 1'b0, 7'b0010001};
    tab[8]  = '{1'b0, 2'd0, 3'b010, 1'b0, 1'b0, 7'b1000001};
    tab[9]  = '{1'b1, 2'd3, 3'b000, 1'b0, 1'b0, 7'b1001001};
    tab[10] = '{1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 7'b1000001};
    for (int i = 0; i < 11; i++) begin
      entradas(tab[i].valid, tab[i].dest, tab[i].sens, tab[i].alarm, tab[i].limpar);
      @(posedge clk);
      @(negedge clk);
      verificar($sformatf("tabela[%0d]", i), tab[i].esp);
    end

    entradas(1'b0, 2'd0, 3'b000, 1'b0, 1'b0);
    reset_sincronizado();

    // Glitch on the destination sensor, then timeout at exactly T cycles.
    entradas(1'b1, 2'd2, 3'b000, 1'b0, 1'b0);
    passo("glitch_aceite");
    k = 0;
    viu_tarefa = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      entradas(1'b0, 2'd0, (i <= 2) ? 3'b100 : 3'b000, 1'b0, 1'b0);
      passo("glitch_mov");
      if (tarefa_concluida) viu_tarefa = 1'b1;
      if (falha_timeout) begin k = i; break; end
    end
    checar("timeout_ciclos", k, T);
    checar("glitch_sem_tarefa", int'(viu_tarefa), 0);

    // Fault ignores commands until cleared.
    entradas(1'b1, 2'd0, 3'b001, 1'b0, 1'b0);
    passo("falha_ignora_cmd");
    passo("falha_ignora_cmd");
    entradas(1'b0, 2'd0, 3'b000, 1'b0, 1'b1);
    passo("falha_limpa");
    checar("limpa_falha_zero", int'(falha_timeout), 0);
    entradas(1'b0, 2'd0, 3'b000, 1'b0, 1'b0);
    passo("pos_limpa");

    // Alarm pause mid-move; paused cycles must not count toward timeout.
    entradas(1'b1, 2'd0, 3'b000, 1'b0, 1'b0);
    passo("pausa_aceite");
    entradas(1'b0, 2'd0, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) passo("pausa_antes");
    viu_tarefa = 1'b0;
    viu_falha  = 1'b0;
    entradas(1'b0, 2'd0, 3'b001, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      passo("pausa_ativa");
      if (motor_ativo) viu_falha = 1'b1;
    end
    checar("pausa_motor_parado", int'(viu_falha), 0);
    entradas(1'b0, 2'd0, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) passo("pausa_depois");
    entradas(1'b0, 2'd0, 3'b001, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      passo("pausa_chegada");
      if (falha_timeout) viu_falha = 1'b1;
      if (tarefa_concluida) begin viu_tarefa = 1'b1; break; end
    end
    checar("pausa_chegou", int'(viu_tarefa), 1);
    checar("pausa_sem_timeout", int'(viu_falha), 0);
    entradas(1'b0, 2'd0, 3'b000, 1'b0, 1'b0);
    passo("pausa_idle");

    // Arrival confirmed on the same edge the timeout terminates.
    entradas(1'b1, 2'd1, 3'b000, 1'b0, 1'b0);
    passo("simult_aceite");
    for (int i = 1; i <= T; i++) begin
      entradas(1'b0, 2'd0, (i > T - F) ? 3'b010 : 3'b000, 1'b0, 1'b0);
      passo("simult_mov");
    end
    checar("simult_tarefa", int'(tarefa_concluida), 1);
    checar("simult_sem_falha", int'(falha_timeout), 0);
    entradas(1'b0, 2'd0, 3'b000, 1'b0, 1'b0);
    passo("simult_idle");

    // Asynchronous reset while moving.
    entradas(1'b1, 2'd2, 3'b000, 1'b0, 1'b0);
    passo("rst_aceite");
    entradas(1'b0, 2'd0, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) passo("rst_mov");
    #2 reset_n = 1'b0;
    #1 verificar("reset_assincrono", 7'b1000000);
    modelo_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      entradas(($urandom % 4) == 0, 2'($urandom % 4),
               {($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 4) != 0},
               ($urandom % 16) == 0, ($urandom % 8) == 0);
      passo("aleatorio");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/esteira_multiestacao.md
# esteira_multiestacao

Parametrised conveyor-motion controller for the bottling line. A single FSM replaces the three per-destination conveyor instances (fill, quality control, exit). It moves the conveyor to any of `N_ESTACOES` sensor-marked stations through a valid/ready command handshake. Beyond the single-destination predecessor, it adds:
- sensor glitch filtering;
- pause while the cork alarm is active;
- a motion timeout with a latched fault;
- rejection of out-of-range destinations.

It sits between `fsm_mestre` and the motor LED/actuator.

## Interface
Parameters:
- `N_ESTACOES`, 3, number of destination stations/sensors (≥1)
- `FILTRO_CICLOS`, 4, consecutive high samples required to confirm arrival (≥1)
- `TIMEOUT_CICLOS`, 500_000_000, maximum cycles in motion before fault (10 s at 50 MHz)
- `IDX_W`, derived: `$clog2(N_ESTACOES)` if `N_ESTACOES`>1, else 1

Ports:
- `clk`  in  1  system clock (50 MHz)
- `reset_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  move request
- `cmd_destino`  in  IDX_W  destination station index
- `cmd_ready`  out  1  high only in IDLE
- `sensores`  in  N_ESTACOES  position sensors; bit i = station i
- `alarme_rolha`  in  1  pause request (level)
- `limpar_falha`  in  1  clears latched fault (level, sampled)
- `motor_ativo`  out  1  conveyor motor enable
- `tarefa_concluida`  out  1  one-cycle arrival pulse
- `cmd_erro`  out  1  one-cycle pulse: destination ≥ N_ESTACOES
- `falha_timeout`  out  1  latched timeout fault
- `estacao_atual`  out  IDX_W  last confirmed station

## Operation
- States: IDLE, MOVENDO, PAUSADO, CONCLUIDO, FALHA.
- IDLE: `cmd_ready`=1.
  - `cmd_valid` with a valid index: latch the destination, clear both counters, go to MOVENDO.
  - `cmd_valid` with an invalid index: pulse `cmd_erro` next cycle and stay in IDLE.
- MOVENDO: `motor_ativo`=1.
  - Filter counter increments on each edge where `sensores[dest]`=1. It resets to 0 on any low sample.
  - Timeout counter increments every edge.
- Priority in MOVENDO, highest first:
  1. `alarme_rolha`=1: go to PAUSADO.
  2. Filter reaches `FILTRO_CICLOS`: go to CONCLUIDO.
  3. Timeout reaches `TIMEOUT_CICLOS`: go to FALHA.
- Arrival wins over timeout in the same cycle.
- PAUSADO: `motor_ativo`=0.
  - Both counters hold; the filter counter is then cleared on exit.
  - `alarme_rolha`=0: return to MOVENDO.
- CONCLUIDO: lasts one cycle.
  - `tarefa_concluida`=1 and `estacao_atual`←dest.
  - Then IDLE.
- FALHA: `motor_ativo`=0 and `falha_timeout`=1.
  - `limpar_falha`=1: go to IDLE and clear `falha_timeout`.
  - Commands are ignored.
- If the destination sensor is already high at accept, the move still runs. The motor turns on for at least `FILTRO_CICLOS` cycles.
- Sensors of non-destination stations are ignored.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE;
  - `cmd_ready`=1;
  - `motor_ativo`, `tarefa_concluida`, `cmd_erro`, `falha_timeout` = 0;
  - `estacao_atual`=0;
  - counters = 0.
- Reset mid-operation: all outputs take their reset values asynchronously. Any pending command is lost.
- Command accepted at edge k: `motor_ativo`=1 and `cmd_ready`=0 from cycle k+1.
- Sensor high from edge m onward: the `FILTRO_CICLOS`-th high sample is at edge m+F-1. From that edge, for one cycle:
  - `tarefa_concluida`=1 and `motor_ativo`=0.
  - After that cycle, `cmd_ready`=1.
- Back-to-back commands: earliest accept is 2 cycles after arrival, i.e. the cycle following the CONCLUIDO cycle.
- Timeout: with no arrival and no pause, `falha_timeout` rises exactly `TIMEOUT_CICLOS` cycles after the first MOVENDO cycle.
- Pause entry or exit takes effect on the edge after `alarme_rolha` changes.

## Structure
- Package `pkg_esteira`:
  - state enum `estado_esteira_t`;
  - `IDX_W` helper function;
  - default constants for `FILTRO_CICLOS` and `TIMEOUT_CICLOS`.
- Sub-module `contador_saturado`: a parametrised width/limit counter with inc, hold and clr, and a terminal flag. It is instantiated twice, as the filter counter and the timeout counter.
- The top FSM holds the state register, the destination register and output registers only.

## Test plan
Bench configuration for all scenarios: `N_ESTACOES`=3, `FILTRO_CICLOS`=3, `TIMEOUT_CICLOS`=20.

1. Normal move:
   - Stimulus: cmd dest=1, then `sensores`=3'b010 held from cycle 5.
   - Required: motor high cycles 1–7; `tarefa_concluida` pulse at cycle 8; `estacao_atual`=1.
2. Glitch rejection:
   - Stimulus: dest=2; `sensores[2]` pulses high for 2 cycles, then stays low.
   - Required: no completion; `falha_timeout`=1 at cycle 20; motor 0.
3. Alarm pause:
   - Stimulus: dest=0; alarm for 10 cycles mid-move.
   - Required: motor 0 during the pause; timeout not reached at cycle 20; arrival still completes.
4. Invalid destination:
   - Stimulus: dest=3.
   - Required: `cmd_erro` pulses one cycle; `cmd_ready` stays 1; motor never rises.
5. Fault clear and reset:
   - Stimulus A: in FALHA, assert `limpar_falha`.
   - Required A: IDLE and `falha_timeout`=0 next cycle.
   - Stimulus B: `reset_n` low while in MOVENDO.
   - Required B: motor 0 immediately; `estacao_atual`=0.
6. Simultaneous events:
   - Stimulus: arrival confirmed on the same edge as the timeout terminal.
   - Required: `tarefa_concluida`=1 and `falha_timeout`=0.
